// File: rtl/aes_round_engine_if.sv
// Block/ciphertext handshake bundle between a block source/sink (master) and the AES engine (slave).
interface aes_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_cnt;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy, round_cnt
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy, round_cnt
  );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption with UNROLL chained round stages per clock and on-the-fly key expansion.
//   state  | meaning
//   IDLE   | waiting for a plaintext/key pair
//   BUSY   | applying UNROLL rounds per cycle to state_reg/key_reg
//   DONE   | ciphertext presented, held until out_ready
module aes_round_engine #(
  parameter int NUM_ROUNDS = 10,
  parameter int UNROLL     = 1
) (
  input logic               clk,
  input logic               rst,
  aes_round_engine_if.slave bus
);

  generate
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10 || UNROLL < 1 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_cfg
      $fatal(1, "aes_round_engine: illegal NUM_ROUNDS/UNROLL combination");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte n of a 128-bit block lives at [127-8n -: 8]; byte n is row n%4, column n/4.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [31:0] r);
    logic [7:0] v;
    case (r)
      32'd1:   v = 8'h01;
      32'd2:   v = 8'h02;
      32'd3:   v = 8'h04;
      32'd4:   v = 8'h08;
      32'd5:   v = 8'h10;
      32'd6:   v = 8'h20;
      32'd7:   v = 8'h40;
      32'd8:   v = 8'h80;
      32'd9:   v = 8'h1b;
      32'd10:  v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] generate_key(input logic [31:0] r, input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {SBOX[w3[23:16]] ^ rcon(r), SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [1:0]   state;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] out_data_q;
  logic         out_valid_q;
  logic [3:0]   round_cnt_q;
  logic [3:0]   round_next;
  logic [127:0] stage_state;
  logic [127:0] stage_key;
  logic         accept;

  assign round_next = round_cnt_q + 4'(UNROLL);

  // In DONE the consumer's ready doubles as ours so a result and a new block can swap in one cycle.
  assign bus.in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state == S_BUSY);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.round_cnt = round_cnt_q;

  always_comb begin : round_stages
    logic [127:0] s;
    logic [127:0] k;
    logic [127:0] sr;
    logic [31:0]  rnd;
    s   = state_reg;
    k   = key_reg;
    sr  = '0;
    rnd = '0;
    for (int j = 0; j < UNROLL; j++) begin
      rnd = 32'(round_cnt_q) + 32'(j + 1);
      k   = generate_key(rnd, k);
      sr  = shift_rows(sub_bytes(s));
      s   = (rnd == 32'(NUM_ROUNDS)) ? (sr ^ k) : (mix_columns(sr) ^ k);
    end
    stage_state = s;
    stage_key   = k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      state_reg   <= '0;
      key_reg     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      round_cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_reg   <= bus.in_data ^ bus.in_key;
            key_reg     <= bus.in_key;
            round_cnt_q <= '0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          state_reg   <= stage_state;
          key_reg     <= stage_key;
          round_cnt_q <= round_next;
          if (round_next == 4'(NUM_ROUNDS)) begin
            out_data_q  <= stage_state;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              state_reg   <= bus.in_data ^ bus.in_key;
              key_reg     <= bus.in_key;
              round_cnt_q <= '0;
              state       <= S_BUSY;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: four configurations (10/1, 10/5, 10/10, 1/1) against known-answer vectors.
`timescale 1ns/1ps
module tb_aes_round_engine;

  localparam int NDUT = 4;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  // One round on App. B: ShiftRows(SubBytes(pt^key)) ^ round key 1.
  localparam logic [127:0] CT_B1 = 128'h7445a32768e07e1f9be228c8344beee0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_ready = 1'b0;
  int           sel = 0;

  logic [NDUT-1:0] in_ready_v;
  logic [NDUT-1:0] out_valid_v;
  logic [NDUT-1:0] busy_v;
  logic [127:0]    out_data_v  [NDUT];
  logic [3:0]      round_cnt_v [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      aes_round_engine_if bus ();
      assign bus.in_valid  = in_valid && (sel == g);
      assign bus.in_data   = in_data;
      assign bus.in_key    = in_key;
      assign bus.out_ready = out_ready && (sel == g);
      assign in_ready_v[g]  = bus.in_ready;
      assign out_valid_v[g] = bus.out_valid;
      assign busy_v[g]      = bus.busy;
      assign out_data_v[g]  = bus.out_data;
      assign round_cnt_v[g] = bus.round_cnt;
      aes_round_engine #(
        .NUM_ROUNDS(g == 3 ? 1 : 10),
        .UNROLL    (g == 1 ? 5 : (g == 2 ? 10 : 1))
      ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
      );
    end
  endgenerate

  typedef struct {
    int           sel;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
    int           nr;
    string        name;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Presents a block and returns after the accept edge (+1); in_data/in_key are scrambled afterwards.
  task automatic start_block(input int s, input logic [127:0] k, input logic [127:0] p, input string name);
    int cyc;
    sel = s;
    cyc = 0;
    while (!in_ready_v[s] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " in_ready"}, 128'(in_ready_v[s]), 128'd1);
    in_valid = 1'b1;
    in_data  = p;
    in_key   = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, " busy after accept"}, 128'(busy_v[s]), 128'd1);
  endtask

  // Latency counts the accept cycle as cycle 1; inputs change every cycle while waiting.
  task automatic wait_out(input int s, output int n);
    n = 1;
    while (!out_valid_v[s] && n < 40) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume(input int s, input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " out_valid after handshake"}, 128'(out_valid_v[s]), 128'd0);
    chk({name, " idle in_ready"}, 128'(in_ready_v[s]), 128'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start_block(v.sel, v.key, v.pt, v.name);
    wait_out(v.sel, n);
    chk({v.name, " latency"}, 128'(n), 128'(v.lat));
    chk({v.name, " out_data"}, out_data_v[v.sel], v.ct);
    chk({v.name, " round_cnt"}, 128'(round_cnt_v[v.sel]), 128'(v.nr));
    chk({v.name, " busy in DONE"}, 128'(busy_v[v.sel]), 128'd0);
    consume(v.sel, v.name);
    chk({v.name, " out_data retained"}, out_data_v[v.sel], v.ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{0, KEY_B, PT_B, CT_B,  11, 10, "b_u1"};
    vecs[1] = '{0, KEY_C, PT_C, CT_C,  11, 10, "c_u1"};
    vecs[2] = '{1, KEY_C, PT_C, CT_C,  3,  10, "c_u5"};
    vecs[3] = '{2, KEY_C, PT_C, CT_C,  2,  10, "c_u10"};
    vecs[4] = '{3, KEY_B, PT_B, CT_B1, 2,  1,  "b_nr1"};
    vecs[5] = '{2, KEY_B, PT_B, CT_B,  2,  10, "b_u10"};
    vecs[6] = '{1, KEY_B, PT_B, CT_B,  3,  10, "b_u5"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 128'(in_ready_v), 128'd0);
    chk("reset out_valid", 128'(out_valid_v), 128'd0);
    chk("reset busy", 128'(busy_v), 128'd0);
    chk("reset round_cnt", 128'(round_cnt_v[0]), 128'd0);
    chk("reset out_data", out_data_v[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 128'(in_ready_v), 128'hf);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure: hold the result, then swap it for a new block in one cycle.
    start_block(0, KEY_B, PT_B, "bp");
    wait_out(0, n);
    chk("bp latency", 128'(n), 128'd11);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp out_data held", out_data_v[0], CT_B);
      chk("bp in_ready low", 128'(in_ready_v[0]), 128'd0);
      chk("bp round_cnt", 128'(round_cnt_v[0]), 128'd10);
      chk("bp out_valid", 128'(out_valid_v[0]), 128'd1);
    end
    in_data   = PT_C;
    in_key    = KEY_C;
    out_ready = 1'b1;
    #1;
    chk("bp swap in_ready", 128'(in_ready_v[0]), 128'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp swap busy", 128'(busy_v[0]), 128'd1);
    chk("bp swap out_valid", 128'(out_valid_v[0]), 128'd0);
    chk("bp swap round_cnt", 128'(round_cnt_v[0]), 128'd0);
    wait_out(0, n);
    chk("bp second latency", 128'(n), 128'd11);
    chk("bp second out_data", out_data_v[0], CT_C);
    consume(0, "bp");

    // Asynchronous reset while round 4 is the last completed round.
    start_block(0, KEY_B, PT_B, "rst_flight");
    n = 0;
    while (round_cnt_v[0] != 4'd4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_flight reached round 4", 128'(round_cnt_v[0]), 128'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_flight out_valid", 128'(out_valid_v[0]), 128'd0);
    chk("rst_flight busy", 128'(busy_v[0]), 128'd0);
    chk("rst_flight round_cnt", 128'(round_cnt_v[0]), 128'd0);
    chk("rst_flight out_data", out_data_v[0], 128'd0);
    chk("rst_flight in_ready", 128'(in_ready_v[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_flight no stale output", 128'(out_valid_v[0]), 128'd0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
